// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one registered valid/ready FIFO upstream port among NUM_REQ
// producers. Define FIFO_ARB_PKT_LOCK_EN to hold the grant until a beat with last (MSB) set.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 33,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_fifo_valid,
    output logic [DATA_W-1:0]         o_fifo_data,
    input  logic                      i_fifo_ready,
    output logic [IDX_W-1:0]          o_grant_id,
    output logic                      o_busy
);

    logic                r_fifo_valid;
    logic [DATA_W-1:0]   r_fifo_data;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant_id;

    logic                w_load_en;
    logic                w_found;
    logic                w_accept;
    logic                w_idle_accept;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_next_ptr;
    logic [IDX_W:0]      w_scan;
    logic [NUM_REQ-1:0]  w_ready;
    logic [DATA_W-1:0]  w_sel_data;

`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic               r_state;
    logic [IDX_W-1:0]   r_lock_id;

    assign o_busy = (r_state == ST_LOCKED);
`else
    assign o_busy = 1'b0;
`endif

    assign w_load_en = ~r_fifo_valid | i_fifo_ready;

    // First valid requester at or after r_rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req_valid[w_scan[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_sel   = w_winner;
`ifdef FIFO_ARB_PKT_LOCK_EN
        if (r_state == ST_LOCKED) begin
            w_sel              = r_lock_id;
            w_ready[r_lock_id] = w_load_en;
        end else
`endif
        if (w_load_en && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    assign o_req_ready   = w_ready & {NUM_REQ{nrst}};
    assign w_accept      = |(i_req_valid & o_req_ready);
    assign w_idle_accept = w_accept & ~o_busy;
    assign w_sel_data    = i_req_data[w_sel*DATA_W +: DATA_W];
    assign w_next_ptr    = (w_winner == IDX_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fifo_valid <= 1'b0;
            r_fifo_data  <= '0;
            r_grant_id   <= '0;
        end else if (w_accept) begin
            r_fifo_valid <= 1'b1;
            r_fifo_data  <= w_sel_data;
            r_grant_id   <= w_sel;
        end else if (w_load_en) begin
            r_fifo_valid <= 1'b0;
        end
    end

    // Pointer only advances on unlocked grants so a packet does not cost its owner a turn.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_ptr <= '0;
        end else if (w_idle_accept) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

`ifdef FIFO_ARB_PKT_LOCK_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_IDLE;
            r_lock_id <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE && !w_sel_data[DATA_W-1]) begin
                r_state   <= ST_LOCKED;
                r_lock_id <= w_winner;
            end else if (r_state == ST_LOCKED && w_sel_data[DATA_W-1]) begin
                r_state <= ST_IDLE;
            end
        end
    end
`endif

    assign o_fifo_valid = r_fifo_valid;
    assign o_fifo_data  = r_fifo_data;
    assign o_grant_id   = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=33); lock scenarios follow
// FIFO_ARB_PKT_LOCK_EN.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         nrst;
    logic [3:0]   req_valid;
    logic [131:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_valid;
    logic [32:0]  fifo_data;
    logic         fifo_ready;
    logic [1:0]   grant_id;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] beats [4][8];
    int          head [4];
    int          cnt [4];
    logic [3:0]  hold;
    logic [32:0] out_log [64];
    int          out_n;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(33)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_fifo_valid (fifo_valid),
        .o_fifo_data  (fifo_data),
        .i_fifo_ready (fifo_ready),
        .o_grant_id   (grant_id),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    function automatic logic [32:0] mk(logic last, int id, int seq);
        return {last, 8'(id), 24'(seq)};
    endfunction

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        hold  = 4'b0;
        out_n = 0;
    endtask

    task automatic add_beat(int r, logic [32:0] b);
        beats[r][cnt[r]] = b;
        cnt[r]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = (head[i] < cnt[i]) && !hold[i];
            req_data[i*33 +: 33]  = (head[i] < cnt[i]) ? beats[i][head[i]] : 33'd0;
        end
    endtask

    // One clock: sample handshakes at the falling edge, update requesters after the rising edge.
    task automatic cycle();
        logic [3:0] acc;
        @(negedge clk);
        if (fifo_valid && fifo_ready && out_n < 64) begin
            out_log[out_n] = fifo_data;
            out_n++;
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) head[i]++;
        end
        apply_inputs();
    endtask

    task automatic do_reset();
        nrst       = 1'b0;
        fifo_ready = 1'b1;
        clear_q();
        apply_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst       = 1'b0;
        fifo_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) add_beat(i, mk(1'b1, i, 0));
        apply_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (req_ready !== 4'b0) begin
            $display("FAIL rst_ready: got %b want 0000", req_ready); n_fail++;
        end
        if (fifo_valid !== 1'b0) begin
            $display("FAIL rst_fifo_valid: got %b want 0", fifo_valid); n_fail++;
        end
        if (fifo_data !== 33'd0) begin
            $display("FAIL rst_fifo_data: got %h want 0", fifo_data); n_fail++;
        end
        if (grant_id !== 2'd0) begin
            $display("FAIL rst_grant_id: got %0d want 0", grant_id); n_fail++;
        end
        if (busy !== 1'b0) begin
            $display("FAIL rst_busy: got %b want 0", busy); n_fail++;
        end
        nrst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL rst_first_ready: got %b want 0001", req_ready); n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks += 3;
        if (grant_id !== 2'd0) begin
            $display("FAIL rst_first_grant: got %0d want 0", grant_id); n_fail++;
        end
        if (fifo_valid !== 1'b1) begin
            $display("FAIL rst_first_valid: got %b want 1", fifo_valid); n_fail++;
        end
        if (fifo_data !== mk(1'b1, 0, 0)) begin
            $display("FAIL rst_first_data: got %h want %h", fifo_data, mk(1'b1, 0, 0)); n_fail++;
        end
    endtask

    task automatic test_rotation();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        int exp_s [5] = '{0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_beat(i, mk(1'b1, i, 0));
            add_beat(i, mk(1'b1, i, 1));
        end
        apply_inputs();
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_checks += 3;
            if (grant_id !== 2'(exp_g[c])) begin
                $display("FAIL rot_grant[%0d]: got %0d want %0d", c, grant_id, exp_g[c]); n_fail++;
            end
            if (fifo_valid !== 1'b1) begin
                $display("FAIL rot_valid[%0d]: got %b want 1", c, fifo_valid); n_fail++;
            end
            if (fifo_data !== mk(1'b1, exp_g[c], exp_s[c])) begin
                $display("FAIL rot_data[%0d]: got %h want %h", c, fifo_data,
                         mk(1'b1, exp_g[c], exp_s[c]));
                n_fail++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_out [3];
        int guard;
        exp_out[0] = mk(1'b1, 0, 0);
        exp_out[1] = mk(1'b1, 1, 0);
        exp_out[2] = mk(1'b1, 0, 1);
        do_reset();
        add_beat(0, mk(1'b1, 0, 0));
        add_beat(0, mk(1'b1, 0, 1));
        add_beat(1, mk(1'b1, 1, 0));
        apply_inputs();
        cycle();
        fifo_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0) begin
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); n_fail++;
            end
            cycle();
            n_checks++;
            if (fifo_valid !== 1'b1 || fifo_data !== exp_out[0]) begin
                $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", c, fifo_valid, fifo_data,
                         exp_out[0]);
                n_fail++;
            end
        end
        fifo_ready = 1'b1;
        guard = 0;
        while (out_n < 3 && guard < 20) begin
            cycle();
            guard++;
        end
        n_checks++;
        if (out_n != 3) begin
            $display("FAIL bp_count: got %0d want 3", out_n); n_fail++;
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (out_log[k] !== exp_out[k]) begin
                    $display("FAIL bp_order[%0d]: got %h want %h", k, out_log[k], exp_out[k]);
                    n_fail++;
                end
            end
        end
    endtask

    // Same stimulus checks both builds; only the expected order and busy differ.
    task automatic test_packet_lock();
`ifdef FIFO_ARB_PKT_LOCK_EN
        int exp_g [6] = '{0, 1, 1, 1, 2, 0};
        int exp_s [6] = '{0, 0, 1, 2, 0, 1};
        int exp_l [6] = '{1, 0, 0, 1, 1, 1};
        int exp_b [6] = '{0, 1, 1, 0, 0, 0};
`else
        int exp_g [6] = '{0, 1, 2, 0, 1, 1};
        int exp_s [6] = '{0, 0, 0, 1, 1, 2};
        int exp_l [6] = '{1, 0, 1, 1, 0, 1};
        int exp_b [6] = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        add_beat(0, mk(1'b1, 0, 0));
        add_beat(0, mk(1'b1, 0, 1));
        add_beat(1, mk(1'b0, 1, 0));
        add_beat(1, mk(1'b0, 1, 1));
        add_beat(1, mk(1'b1, 1, 2));
        add_beat(2, mk(1'b1, 2, 0));
        apply_inputs();
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_checks += 3;
            if (grant_id !== 2'(exp_g[c])) begin
                $display("FAIL pkt_grant[%0d]: got %0d want %0d", c, grant_id, exp_g[c]); n_fail++;
            end
            if (busy !== 1'(exp_b[c])) begin
                $display("FAIL pkt_busy[%0d]: got %b want %0d", c, busy, exp_b[c]); n_fail++;
            end
            if (fifo_data !== mk(1'(exp_l[c]), exp_g[c], exp_s[c])) begin
                $display("FAIL pkt_data[%0d]: got %h want %h", c, fifo_data,
                         mk(1'(exp_l[c]), exp_g[c], exp_s[c]));
                n_fail++;
            end
        end
    endtask

`ifdef FIFO_ARB_PKT_LOCK_EN
    task automatic test_lock_stall();
        int exp_g [4] = '{1, 1, 2, 3};
        int exp_b [4] = '{1, 0, 0, 0};
        do_reset();
        add_beat(1, mk(1'b0, 1, 0));
        add_beat(1, mk(1'b0, 1, 1));
        add_beat(1, mk(1'b1, 1, 2));
        add_beat(2, mk(1'b1, 2, 0));
        add_beat(3, mk(1'b1, 3, 0));
        apply_inputs();
        cycle();
        hold[1] = 1'b1;
        apply_inputs();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0010) begin
                $display("FAIL stall_ready[%0d]: got %b want 0010", c, req_ready); n_fail++;
            end
            cycle();
            n_checks += 3;
            if (grant_id !== 2'd1) begin
                $display("FAIL stall_grant[%0d]: got %0d want 1", c, grant_id); n_fail++;
            end
            if (busy !== 1'b1) begin
                $display("FAIL stall_busy[%0d]: got %b want 1", c, busy); n_fail++;
            end
            if (fifo_valid !== 1'b0) begin
                $display("FAIL stall_valid[%0d]: got %b want 0", c, fifo_valid); n_fail++;
            end
        end
        hold[1] = 1'b0;
        apply_inputs();
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_checks += 2;
            if (grant_id !== 2'(exp_g[c])) begin
                $display("FAIL resume_grant[%0d]: got %0d want %0d", c, grant_id, exp_g[c]);
                n_fail++;
            end
            if (busy !== 1'(exp_b[c])) begin
                $display("FAIL resume_busy[%0d]: got %b want %0d", c, busy, exp_b[c]); n_fail++;
            end
        end
    endtask
`endif

    initial begin
        nrst       = 1'b0;
        fifo_ready = 1'b1;
        req_valid  = 4'b0;
        req_data   = '0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_packet_lock();
`ifdef FIFO_ARB_PKT_LOCK_EN
        test_lock_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the 33-bit valid/ready upstream port of the team's synchronous FIFO among several producers. Each cycle it selects one requester, passes its beat through a single output register, and drives the FIFO write port. Optional packet locking keeps a multi-beat packet contiguous in the FIFO, using the data MSB as the end-of-packet flag.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2–16.
- DATA_W, 33, beat width; bit DATA_W-1 is the `last` flag.
- IDX_W, $clog2(NUM_REQ), width of requester index (derived; do not override).

- clk  in  1  clock; all state on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- fifo_valid  out  1  beat valid toward the FIFO upstream port.
- fifo_data  out  DATA_W  beat toward the FIFO.
- fifo_ready  in  1  FIFO not full.
- grant_id  out  IDX_W  index of the most recently accepted requester.
- busy  out  1  high while a packet lock is held.

## Operation
- Output register: `load_en = ~fifo_valid | fifo_ready`. A beat is accepted from requester i when req_valid[i] & req_ready[i]. The accepted beat loads fifo_data and sets fifo_valid. With load_en high and no accept, fifo_valid clears. `last` and all data bits pass unmodified.
- State IDLE:
  - When load_en=1, scan from rr_ptr upward with wrap (NUM_REQ-1 → 0). The first requester with req_valid=1 wins.
  - req_ready is asserted only for the winner; all others are 0.
  - On accept: rr_ptr <= (winner+1) mod NUM_REQ and grant_id <= winner.
- State LOCKED (macro only):
  - Only lock_id is eligible; req_ready[lock_id] = load_en.
  - rr_ptr is frozen.
  - Accepting a beat with last=1 returns the block to IDLE.
- Transition IDLE→LOCKED occurs on accept of a beat with last=0; lock_id <= winner.
- Requester contract: valid and data are held stable until accepted. The arbiter never withdraws req_ready while load_en and req_valid stay high.
- busy = (state == LOCKED).
- Reset values:
  - fifo_valid=0, fifo_data=0, rr_ptr=0, grant_id=0, state=IDLE, busy=0.
  - req_ready all 0 while nrst=0.
- Boundaries:
  - fifo_valid=1 with fifo_ready=0: hold fifo_data; all req_ready=0.
  - Locked requester drops valid mid-packet: wait indefinitely. No bubble insertion, no timeout, no other requester served.
  - All req_valid=0 in IDLE: no accept; rr_ptr unchanged.
  - Reset mid-packet: lock and in-flight beat are discarded.

## Timing
- Latency 1 cycle: a beat accepted at edge N appears on fifo_valid/fifo_data after edge N.
- Throughput 1 beat/cycle while fifo_ready=1.
- req_ready is combinational from fifo_valid, fifo_ready, req_valid and state. The fifo_ready→req_ready path is combinational and is accepted by design.
- The FIFO sees no combinational path from req_* to fifo_*.
- Fairness, IDLE: with all requesters continuously valid and single-beat packets, grants rotate 0,1,…,NUM_REQ-1. Maximum wait is NUM_REQ-1 grants (packets under lock).

## Configuration
- FIFO_ARB_PKT_LOCK_EN:
  - Defined: IDLE/LOCKED FSM as above; packets from one requester are contiguous in the FIFO.
  - Undefined: LOCKED state and lock_id are not built. Every beat is arbitrated independently, `last` is ignored for control, and busy is tied 0.

## Test plan
- Reset: nrst low for 3 cycles with all req_valid=1 → req_ready=0, fifo_valid=0, fifo_data=0, grant_id=0; first accept after release is requester 0.
- Rotation: NUM_REQ=4, all valid, last=1 on every beat, fifo_ready=1 → grant_id sequence 0,1,2,3,0; one beat per cycle, each appearing 1 cycle after its accept.
- Backpressure: fifo_ready=0 for 5 cycles while fifo_valid=1 → fifo_data stable and all req_ready=0; fifo_ready=1 → transfer resumes with no lost or duplicated beat.
- Packet lock (macro defined): req 1 sends 3 beats (last only on beat 3) while req 0 and req 2 are valid → FIFO receives the 3 beats of req 1 contiguously, busy=1 until beat 3 is accepted, then req 2 is granted.
- Stall in lock (macro defined): req 1 drops valid after beat 1 for 4 cycles → no other requester granted; busy stays 1.
- Lock disabled (macro undefined): same stimulus as the packet-lock scenario → beats of req 1 interleave with req 2 and req 0 in round-robin order; busy=0 throughout.
